// File: rtl/uc_seq_if.sv
// Control-unit bundle: datapath status/opcode in, datapath select/enable lines out.
// The master side is the datapath (or a bench); the slave side is uc_seq.
interface uc_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             zero;
    logic             run;
    logic             s_inc;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic [2:0]       ALUOp;
    logic             pc_hold;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output Opcode, zero, run,
        input  s_inc, s_inm, we, wez, ALUOp, pc_hold, halted, err, instr_count
    );

    modport slave (
        input  Opcode, zero, run,
        output s_inc, s_inm, we, wez, ALUOp, pc_hold, halted, err, instr_count
    );
endinterface

// File: rtl/uc_seq.sv
// Sequenced control unit for the 8-bit microcontroller datapath: Mealy decode in RUN,
// multi-cycle WAIT, HALT/resume, sticky illegal-opcode trap and retired-instruction counter.
module uc_seq #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic      clk,
    input  logic      reset,
    uc_seq_if.slave   io_bus
);

    localparam int unsigned WCNT_W = 8;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 3;

    localparam logic [OP_W-1:0] OP_J    = 6'b000100;
    localparam logic [OP_W-1:0] OP_JZ   = 6'b000101;
    localparam logic [OP_W-1:0] OP_JNZ  = 6'b000110;
    localparam logic [OP_W-1:0] OP_WAIT = 6'b001000;
    localparam logic [OP_W-1:0] OP_HALT = 6'b001001;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [WCNT_W-1:0]   w_wait_cnt_nxt;
    logic                r_halted;
    logic                r_err;
    logic [CNT_W-1:0]    r_instr_count;
    logic                w_set_err;

    logic                w_s_inc;
    logic                w_s_inm;
    logic                w_we;
    logic                w_wez;
    logic [ALU_W-1:0]    w_alu_op;
    logic                w_pc_hold;

    logic [OP_W-1:0]     w_op;
    logic                w_op_alu;
    logic                w_op_li;
    logic                w_op_j;
    logic                w_op_jz;
    logic                w_op_jnz;
    logic                w_op_wait;
    logic                w_op_halt;
    logic                w_op_illegal;

    // Opcode classification
    assign w_op         = io_bus.Opcode;
    assign w_op_alu     = w_op[5];
    assign w_op_li      = (w_op[5:2] == 4'b0000);
    assign w_op_j       = (w_op == OP_J);
    assign w_op_jz      = (w_op == OP_JZ);
    assign w_op_jnz     = (w_op == OP_JNZ);
    assign w_op_wait    = (w_op == OP_WAIT);
    assign w_op_halt    = (w_op == OP_HALT);
    // 001010..011111: bit 5 clear and low five bits at or above 01010
    assign w_op_illegal = !w_op[5] && (w_op[4:0] >= 5'b01010);

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_set_err      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_op_wait) begin
                    w_next_state   = ST_WAIT;
                    w_wait_cnt_nxt = WCNT_W'(WAIT_CYCLES - 32'd1);
                end else if (w_op_halt) begin
                    w_next_state = ST_HALT;
                end else if (w_op_illegal) begin
                    w_next_state = ST_HALT;
                    w_set_err    = 1'b1;
                end
            end
            ST_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt - WCNT_W'(1);
                if (r_wait_cnt == WCNT_W'(1)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_HALT: begin
                if (io_bus.run && !r_err) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state   = ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Mealy output decode; reset overrides everything with a PC-holding, write-free set
    always_comb begin
        w_s_inc   = 1'b1;
        w_s_inm   = 1'b0;
        w_we      = 1'b0;
        w_wez     = 1'b0;
        w_alu_op  = '0;
        w_pc_hold = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_op_alu) begin
                    w_alu_op = w_op[4:2];
                    w_we     = 1'b1;
                    w_wez    = 1'b1;
                end else if (w_op_li) begin
                    w_s_inm = 1'b1;
                    w_we    = 1'b1;
                end else if (w_op_j) begin
                    w_s_inc = 1'b0;
                end else if (w_op_jz) begin
                    w_s_inc = !io_bus.zero;
                end else if (w_op_jnz) begin
                    w_s_inc = io_bus.zero;
                end else if (w_op_wait || w_op_halt || w_op_illegal) begin
                    w_pc_hold = 1'b1;
                end
            end
            ST_WAIT: begin
                w_pc_hold = (r_wait_cnt != WCNT_W'(1));
            end
            ST_HALT: begin
                w_pc_hold = !(io_bus.run && !r_err);
            end
            default: begin
                w_pc_hold = 1'b1;
            end
        endcase
        if (!reset) begin
            w_s_inc   = 1'b1;
            w_s_inm   = 1'b0;
            w_we      = 1'b0;
            w_wez     = 1'b0;
            w_alu_op  = '0;
            w_pc_hold = 1'b1;
        end
    end

    // Status flags and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_halted      <= 1'b0;
            r_err         <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_halted <= (w_next_state == ST_HALT);
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (!w_pc_hold) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    assign io_bus.s_inc       = w_s_inc;
    assign io_bus.s_inm       = w_s_inm;
    assign io_bus.we          = w_we;
    assign io_bus.wez         = w_wez;
    assign io_bus.ALUOp       = w_alu_op;
    assign io_bus.pc_hold     = w_pc_hold;
    assign io_bus.halted      = r_halted;
    assign io_bus.err         = r_err;
    assign io_bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_uc_seq.sv
// Randomized bench for uc_seq: each cycle's outputs are compared against an
// instruction-level reference model of the sequencer kept in the bench.
module tb_uc_seq;

    localparam int unsigned WC = 4;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset;

    uc_seq_if #(.CNT_W(CW)) bus ();

    uc_seq #(.WAIT_CYCLES(WC), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: what the machine is doing at instruction level
    typedef enum {M_RUN, M_WAIT, M_HALT} mode_e;
    mode_e       m_mode  = M_RUN;
    int          m_left  = 0;
    bit          m_err   = 1'b0;
    int unsigned m_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expected {s_inc, s_inm, we, wez, ALUOp, pc_hold} for the current model state
    function automatic logic [7:0] exp_ctl(input logic [5:0] op, input logic z,
                                           input logic rn, input logic rs);
        logic si, sm, w, wz, h;
        logic [2:0] a;
        int v;
        si = 1'b1; sm = 1'b0; w = 1'b0; wz = 1'b0; h = 1'b0; a = 3'd0;
        v = int'(op);
        if (!rs)                   h = 1'b1;
        else if (m_mode == M_WAIT) h = (m_left != 1);
        else if (m_mode == M_HALT) h = !(rn && !m_err);
        else if (v >= 32) begin a = op[4:2]; w = 1'b1; wz = 1'b1; end
        else if (v < 4)   begin sm = 1'b1; w = 1'b1; end
        else if (v == 4)  si = 1'b0;
        else if (v == 5)  si = !z;
        else if (v == 6)  si = z;
        else if (v >= 8)  h = 1'b1;
        return {si, sm, w, wz, a, h};
    endfunction

    task automatic model_step(input logic [5:0] op, input logic rn, input logic rs,
                              input logic hold);
        int v;
        v = int'(op);
        if (!rs) begin
            m_mode = M_RUN; m_left = 0; m_err = 1'b0; m_count = 0;
            return;
        end
        if (!hold) m_count = (m_count + 1) % (1 << CW);
        case (m_mode)
            M_RUN: begin
                if (v == 8) begin m_mode = M_WAIT; m_left = WC - 1; end
                else if (v == 9) m_mode = M_HALT;
                else if (v >= 10 && v < 32) begin m_mode = M_HALT; m_err = 1'b1; end
            end
            M_WAIT: begin
                if (m_left == 1) m_mode = M_RUN;
                m_left--;
            end
            default: if (rn && !m_err) m_mode = M_RUN;
        endcase
    endtask

    // One clock: drive, check mid-cycle, advance model on the edge
    task automatic cycle(input logic [5:0] op, input logic z, input logic rn, input logic rs);
        logic [7:0] ec;
        bus.Opcode = op; bus.zero = z; bus.run = rn; reset = rs;
        @(negedge clk);
        ec = exp_ctl(op, z, rn, rs);
        chk("ctl", 32'({bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.ALUOp, bus.pc_hold}), 32'(ec));
        chk("halted", 32'(bus.halted), 32'(m_mode == M_HALT));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("count", 32'(bus.instr_count), m_count);
        @(posedge clk);
        model_step(op, rn, rs, ec[0]);
        #1;
    endtask

    localparam logic [5:0] NOP = 6'b000111;

    initial begin
        int r;
        logic [5:0] op;
        logic rn, rs;

        // Reset then first NOP
        cycle(NOP, 1'b0, 1'b0, 1'b0);
        cycle(NOP, 1'b0, 1'b0, 1'b0);
        cycle(NOP, 1'b0, 1'b0, 1'b1);
        chk("first_nop_count", 32'(bus.instr_count), 32'd1);

        // ALU and LI
        cycle(6'b101100, 1'b0, 1'b0, 1'b1);
        cycle(6'b000010, 1'b0, 1'b0, 1'b1);

        // Branches against both zero values
        for (int zz = 0; zz < 2; zz++) begin
            cycle(6'b000101, 1'(zz), 1'b0, 1'b1);
            cycle(6'b000110, 1'(zz), 1'b0, 1'b1);
            cycle(6'b000100, 1'(zz), 1'b0, 1'b1);
        end

        // WAIT spans WC cycles; run is irrelevant during it
        cycle(6'b001000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < int'(WC) - 1; i++) cycle(NOP, 1'b0, 1'b1, 1'b1);
        cycle(NOP, 1'b0, 1'b0, 1'b1);

        // HALT, hold 10 cycles, resume
        cycle(6'b001001, 1'b0, 1'b0, 1'b1);
        chk("halted_after_halt", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 10; i++) cycle(NOP, 1'b0, 1'b0, 1'b1);
        cycle(NOP, 1'b0, 1'b1, 1'b1);
        chk("halted_after_run", 32'(bus.halted), 32'd0);
        cycle(NOP, 1'b0, 1'b0, 1'b1);

        // Illegal trap: run ignored until reset
        cycle(6'b011111, 1'b0, 1'b0, 1'b1);
        chk("err_set", 32'(bus.err), 32'd1);
        for (int i = 0; i < 6; i++) cycle(NOP, 1'b0, 1'(i % 2), 1'b1);
        chk("still_halted", 32'(bus.halted), 32'd1);
        cycle(NOP, 1'b0, 1'b1, 1'b0);
        chk("err_cleared", 32'(bus.err), 32'd0);
        cycle(NOP, 1'b0, 1'b0, 1'b1);

        // Counter wrap: 2^CW NOPs from zero land back on zero
        cycle(NOP, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < (1 << CW); i++) cycle(NOP, 1'b0, 1'b0, 1'b1);
        chk("wrap", 32'(bus.instr_count), 32'd0);

        // Reset mid-WAIT aborts it
        cycle(6'b001000, 1'b0, 1'b0, 1'b1);
        cycle(NOP, 1'b0, 1'b0, 1'b1);
        cycle(NOP, 1'b0, 1'b0, 1'b0);
        cycle(6'b101000, 1'b1, 1'b0, 1'b1);
        chk("after_abort_count", 32'(bus.instr_count), 32'd1);

        // Random traffic; illegal opcodes kept rare so HALT/err states get left by reset
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)       op = 6'($urandom_range(10, 31));
            else if (r < 14) op = 6'($urandom_range(8, 9));
            else if (r < 50) op = 6'($urandom_range(0, 7));
            else             op = 6'($urandom_range(32, 63));
            rn = ($urandom_range(0, 99) < 30);
            rs = !(($urandom_range(0, 99) < 2) || (m_err && $urandom_range(0, 99) < 10));
            cycle(op, 1'($urandom_range(0, 1)), rn, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequenced control unit for the 8-bit microcontroller datapath.
- Consumes the 6-bit Opcode and the registered zero flag from the datapath.
- Drives the datapath select/enable lines (s_inc, s_inm, we, wez, ALUOp) plus a PC-hold line.
- Adds multi-cycle WAIT, HALT/resume, illegal-opcode trap and a retired-instruction counter.

Parameters:
- WAIT_CYCLES, 4, total cycles a WAIT instruction occupies, including its issue cycle; legal range 2..255.
- CNT_W, 16, width of instr_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- Opcode  input  6  instruction bits [15:10] from the datapath.
- zero  input  1  registered zero flag from the datapath.
- run  input  1  resume request; only meaningful in HALT.
- s_inc  output  1  1 = PC+1, 0 = load jump target.
- s_inm  output  1  1 = immediate operand / immediate write address.
- we  output  1  register-file write enable.
- wez  output  1  zero-flag write enable.
- ALUOp  output  3  ALU function select.
- pc_hold  output  1  1 = PC keeps its value this cycle.
- halted  output  1  registered; 1 while in HALT state.
- err  output  1  registered, sticky illegal-opcode flag.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- State register: RUN, WAIT, HALT. Reset (reset=0 at posedge) forces state=RUN, wait counter=0, halted=0, err=0, instr_count=0.
- While reset=0, outputs are forced to: we=0, wez=0, pc_hold=1, s_inc=1, s_inm=0, ALUOp=000.
- Default output set (NOP-like): s_inc=1, s_inm=0, we=0, wez=0, ALUOp=000, pc_hold=0.
- Decode in RUN. Outputs are combinational from Opcode, zero and state (Mealy).
  - 1abc__ (ALU reg): ALUOp=abc, we=1, wez=1, s_inm=0.
  - 0000__ (LI): s_inm=1, we=1, wez=0, ALUOp=000.
  - 000100 (J): s_inc=0.
  - 000101 (JZ): s_inc=~zero.
  - 000110 (JNZ): s_inc=zero.
  - 000111 (NOP): defaults.
  - 001000 (WAIT): pc_hold=1, load wait counter with WAIT_CYCLES-1, next=WAIT.
  - 001001 (HALT): pc_hold=1, next=HALT.
  - 001010..011111 (illegal): pc_hold=1, err<=1, next=HALT.
- WAIT state:
  - Counter decrements each cycle; we=wez=0.
  - pc_hold=1 while counter!=1. At counter==1: pc_hold=0, s_inc=1, next=RUN.
  - The whole instruction spans exactly WAIT_CYCLES cycles.
- HALT state:
  - we=wez=0, pc_hold=1; PC remains on the HALT/illegal instruction.
  - If run=1 and err=0: that cycle pc_hold=0, s_inc=1 (step past the instruction), next=RUN.
  - If err=1: run is ignored; exit only by reset.
- halted is a registered copy of (state==HALT).
- instr_count increments by 1 on every cycle in which pc_hold=0 and reset=1. This covers RUN non-stalling instructions, taken/untaken branches, the WAIT exit cycle and the HALT resume cycle. Wraps from all-ones to 0.
- zero hazard: branches use the flag value present at the branch cycle, i.e. the flag written by the most recent wez=1 instruction. No forwarding.
- Simultaneous events: reset dominates everything. run while in RUN or WAIT has no effect. Reset during WAIT aborts it, with no count increment that cycle.

Test Plan:
- Reset low 2 cycles, then high with Opcode=000111 → outputs forced as listed during reset. First NOP cycle: pc_hold=0, s_inc=1. instr_count 0→1.
- Opcode=101100 → ALUOp=011, we=1, wez=1, s_inm=0. Opcode=000010 → s_inm=1, we=1, wez=0.
- zero=1: JZ gives s_inc=0, JNZ gives s_inc=1. zero=0: JZ gives s_inc=1, JNZ gives s_inc=0. J always gives s_inc=0.
- WAIT with WAIT_CYCLES=4 → pc_hold=1 for 3 cycles and 0 on the 4th; state back to RUN. instr_count +1 total.
- HALT → halted=1 next cycle, pc_hold=1 held for 10 cycles. Pulse run=1 → pc_hold=0 that cycle, halted=0 next cycle. Then Opcode=011111 → err=1, halted=1; run pulses ignored until reset clears both.
- Preload instr_count near wrap (run 65536 NOPs) → count wraps to 0. Assert reset mid-WAIT → state=RUN, counter=0, next cycle normal decode.
